// File: rtl/cordic_output_scaler_if.sv
// Beat-level handshake bundle for the CORDIC output scaler.
// Input side carries k/rot_inp, output side the scaled sample.
interface cordic_output_scaler_if #(
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 4
);
  logic               inp_valid;
  logic               inp_ready;
  logic [SHIFT_W-1:0] k;
  logic [DATA_W-1:0]  rot_inp;
  logic [OUT_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_sat;

  modport master (
    output inp_valid,
    output k,
    output rot_inp,
    output out_ready,
    input  inp_ready,
    input  out_data,
    input  out_valid,
    input  out_sat
  );

  modport slave (
    input  inp_valid,
    input  k,
    input  rot_inp,
    input  out_ready,
    output inp_ready,
    output out_data,
    output out_valid,
    output out_sat
  );
endinterface

// File: rtl/cordic_output_scaler.sv
// Denormalising back end of the CORDIC sqrt path: signed shift by k,
// saturate to OUT_W, two-stage pipe with backpressure and a clip counter.
module cordic_output_scaler #(
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  cordic_output_scaler_if.slave io,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam int W1 = DATA_W + 2**(SHIFT_W-1);
  localparam int HW = W1 - OUT_W + 1;

  logic                    v1_q;
  logic signed [W1-1:0]    s1_q;
  logic signed [W1-1:0]    s1_d;
  logic                    v2_q;
  logic [OUT_W-1:0]        out_q;
  logic [OUT_W-1:0]        out_d;
  logic                    sat_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;

  logic                    adv;
  logic signed [W1-1:0]    ext;
  logic signed [W1-1:0]    rnd;
  logic [SHIFT_W-1:0]      n;
  logic [HW-1:0]           hi;
  logic                    ovf;
  logic                    fire;

  assign adv          = io.out_ready | ~v2_q;
  assign io.inp_ready = adv;
  assign io.out_data  = out_q;
  assign io.out_valid = v2_q;
  assign io.out_sat   = sat_q;
  assign sat_cnt      = cnt_q;

  // Stage 1: W1 holds the widest left shift and the rounding add.
  always_comb begin
    ext  = W1'($signed(io.rot_inp));
    n    = SHIFT_W'(0) - io.k;
    rnd  = '0;
    s1_d = '0;
    if (!io.k[SHIFT_W-1]) begin
      s1_d = ext <<< io.k[SHIFT_W-2:0];
    end else begin
      rnd  = W1'(1) <<< (n - SHIFT_W'(1));
      s1_d = (ext + rnd) >>> n;
    end
  end

  // Stage 2: in range only if the bits above the sign all match it.
  always_comb begin
    hi    = s1_q[W1-1:OUT_W-1];
    ovf   = ~(&hi) & (|hi);
    out_d = s1_q[OUT_W-1:0];
    if (ovf) begin
      out_d = s1_q[W1-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                         : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_comb begin
    fire  = v2_q & io.out_ready & sat_q;
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (fire && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q  <= 1'b0;
      s1_q  <= '0;
      v2_q  <= 1'b0;
      out_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (adv) begin
        v1_q  <= io.inp_valid;
        s1_q  <= io.inp_valid ? s1_d : '0;
        v2_q  <= v1_q;
        out_q <= v1_q ? out_d : '0;
        sat_q <= v1_q & ovf;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
